// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, stall vector constants, FSM states and the stall priority encoder.
package pipe_ctrl_pkg;
  localparam int STOP_W = 6;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] INITIAL_PC = 32'h0000_0000;

  // stall bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb, 1 = stop
  localparam logic [STOP_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STOP_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STOP_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STOP_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STOP_W-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH_WAIT = 2'd1,
    FLUSH      = 2'd2
  } state_e;

  // Later stage wins: freezing a later stage must freeze everything upstream.
  function automatic logic [STOP_W-1:0] stall_enc(input logic rq_if, input logic rq_id,
                                                  input logic rq_ex, input logic rq_mem);
    if (rq_mem)     return STALL_MEM;
    else if (rq_ex) return STALL_EX;
    else if (rq_id) return STALL_ID;
    else if (rq_if) return STALL_IF;
    else            return STALL_NONE;
  endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipe_ctrl.
interface pipe_ctrl_if #(parameter int CNT_W = 32);
  import pipe_ctrl_pkg::*;
  logic              stallreq_if;
  logic              stallreq_id;
  logic              stallreq_ex;
  logic              stallreq_mem;
  logic              excp_req;
  logic [ADDR_W-1:0] excp_pc;
  logic [STOP_W-1:0] stall;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              bus_timeout;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excp_req, excp_pc,
                  input  stall, flush, new_pc, bus_timeout, stall_cycles);
  modport slave  (input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excp_req, excp_pc,
                  output stall, flush, new_pc, bus_timeout, stall_cycles);
endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Data-bus stall watchdog: counts consecutive mem-stall cycles, sticky timeout flag.
module stall_watchdog #(
  parameter int MEM_TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic stallreq_mem,
  output logic bus_timeout
);
  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(MEM_TIMEOUT - 1);

  logic [TW-1:0] timer;

  // Timer clears on any non-stall cycle and parks at T_MAX once the flag is raised.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer       <= '0;
      bus_timeout <= 1'b0;
    end else if (!stallreq_mem) begin
      timer <= '0;
    end else if (timer == T_MAX) begin
      bus_timeout <= 1'b1;
    end else begin
      timer <= timer + 1'b1;
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall priority encoder, exception flush FSM, stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave ctl
);
  state_e            state, state_nxt;
  logic [ADDR_W-1:0] pc_lat, pc_nxt;
  logic [STOP_W-1:0] stall_c;
  logic [CNT_W-1:0]  cnt;

  // Next state, redirect latch and stall vector; an accepted exception overrides stall requests.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_lat;
    stall_c   = STALL_NONE;
    case (state)
      RUN: begin
        stall_c = stall_enc(ctl.stallreq_if, ctl.stallreq_id, ctl.stallreq_ex, ctl.stallreq_mem);
        if (ctl.excp_req) begin
          pc_nxt = ctl.excp_pc;
          if (ctl.stallreq_mem) begin
            state_nxt = FLUSH_WAIT;
          end else begin
            state_nxt = FLUSH;
            stall_c   = STALL_NONE;
          end
        end
      end
      // Hold the whole pipe until the data bus completes; later exceptions are ignored.
      FLUSH_WAIT: begin
        if (ctl.stallreq_mem) stall_c = STALL_MEM;
        else                  state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    if (rst) stall_c = STALL_NONE;
  end

  // State, latched redirect target and saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      pc_lat <= INITIAL_PC;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      pc_lat <= pc_nxt;
      if (stall_c != STALL_NONE && cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
    end
  end

  stall_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
    .clk         (clk),
    .rst         (rst),
    .stallreq_mem(ctl.stallreq_mem),
    .bus_timeout (ctl.bus_timeout)
  );

  assign ctl.stall        = stall_c;
  assign ctl.flush        = (state == FLUSH);
  assign ctl.new_pc       = pc_lat;
  assign ctl.stall_cycles = cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: priority table plus exception/watchdog/reset sequences.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(32)) ifc ();
  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (.clk(clk), .rst(rst), .ctl(ifc.slave));

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] req;   // {mem, ex, id, if}
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[10];

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int exp_cnt  = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endtask

  task automatic drive(input logic [3:0] req, input logic ex, input logic [31:0] pc);
    ifc.stallreq_mem = req[3];
    ifc.stallreq_ex  = req[2];
    ifc.stallreq_id  = req[1];
    ifc.stallreq_if  = req[0];
    ifc.excp_req     = ex;
    ifc.excp_pc      = pc;
  endtask

  // One cycle: drive after the edge, sample stall/flush mid-cycle, return just after next edge.
  task automatic cyc(input string n, input logic [3:0] req, input logic ex, input logic [31:0] pc,
                     input logic [5:0] es, input logic ef, input logic [31:0] epc);
    exp_t e;
    drive(req, ex, pc);
    sb.push_back('{stall: es, flush: ef, pc: epc});
    @(negedge clk);
    e = sb.pop_front();
    chk({n, ".stall"}, 32'(ifc.stall), 32'(e.stall));
    chk({n, ".flush"}, 32'(ifc.flush), 32'(e.flush));
    if (e.flush) chk({n, ".new_pc"}, ifc.new_pc, e.pc);
    @(posedge clk);
    if (rst) exp_cnt = 0;
    else if (e.stall != 6'b0) exp_cnt++;
    #1;
  endtask

  initial begin
    tbl[0] = '{4'b0000, 6'b000000};
    tbl[1] = '{4'b0001, 6'b000011};
    tbl[2] = '{4'b0010, 6'b000111};
    tbl[3] = '{4'b0100, 6'b001111};
    tbl[4] = '{4'b1000, 6'b011111};
    tbl[5] = '{4'b0110, 6'b001111};
    tbl[6] = '{4'b1111, 6'b011111};
    tbl[7] = '{4'b0011, 6'b000111};
    tbl[8] = '{4'b1001, 6'b011111};
    tbl[9] = '{4'b0101, 6'b001111};

    // reset with requests asserted: stall forced to 0
    drive(4'b1010, 1'b1, 32'h1234);
    @(posedge clk); #1;
    chk("rst.stall", 32'(ifc.stall), 32'h0);
    chk("rst.flush", 32'(ifc.flush), 32'h0);
    chk("rst.new_pc", ifc.new_pc, INITIAL_PC);
    chk("rst.bus_timeout", 32'(ifc.bus_timeout), 32'h0);
    chk("rst.stall_cycles", ifc.stall_cycles, 32'h0);
    @(posedge clk); #1;
    drive(4'b0000, 1'b0, 32'h0);
    rst = 1'b0;

    // single id bubble
    cyc("t1.id", 4'b0010, 1'b0, 0, 6'b000111, 1'b0, 0);
    cyc("t1.idle", 4'b0000, 1'b0, 0, 6'b000000, 1'b0, 0);
    chk("t1.stall_cycles", ifc.stall_cycles, 32'd1);

    // ex+id for 5 cycles
    for (int i = 0; i < 5; i++) cyc("t2.exid", 4'b0110, 1'b0, 0, 6'b001111, 1'b0, 0);
    chk("t2.stall_cycles", ifc.stall_cycles, 32'd6);

    // priority table
    for (int i = 0; i < 10; i++) cyc($sformatf("tbl%0d", i), tbl[i].req, 1'b0, 0, tbl[i].exp, 1'b0, 0);
    chk("tbl.stall_cycles", ifc.stall_cycles, 32'(exp_cnt));

    // exception without mem stall wins over id request; flush stalls nothing
    cyc("t3.excp", 4'b0010, 1'b1, 32'h40, 6'b000000, 1'b0, 0);
    cyc("t3.flush", 4'b0110, 1'b0, 0, 6'b000000, 1'b1, 32'h40);
    cyc("t3.after", 4'b0000, 1'b0, 0, 6'b000000, 1'b0, 0);

    // exception during mem stall waits for the bus; second target ignored
    cyc("t4.c1", 4'b1000, 1'b1, 32'h80, 6'b011111, 1'b0, 0);
    cyc("t4.c2", 4'b1000, 1'b1, 32'h99, 6'b011111, 1'b0, 0);
    cyc("t4.c3", 4'b1010, 1'b0, 0, 6'b011111, 1'b0, 0);
    cyc("t4.drop", 4'b0000, 1'b0, 0, 6'b000000, 1'b0, 0);
    cyc("t4.flush", 4'b0000, 1'b0, 0, 6'b000000, 1'b1, 32'h80);
    cyc("t4.after", 4'b0000, 1'b0, 0, 6'b000000, 1'b0, 0);
    chk("t4.stall_cycles", ifc.stall_cycles, 32'(exp_cnt));

    // watchdog with MEM_TIMEOUT=4
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t5.bt_pre%0d", i), 32'(ifc.bus_timeout), 32'h0);
      cyc("t5.mem", 4'b1000, 1'b0, 0, 6'b011111, 1'b0, 0);
    end
    chk("t5.bt_set", 32'(ifc.bus_timeout), 32'h1);
    cyc("t5.rel", 4'b0000, 1'b0, 0, 6'b000000, 1'b0, 0);
    cyc("t5.rel2", 4'b0001, 1'b0, 0, 6'b000011, 1'b0, 0);
    chk("t5.bt_sticky", 32'(ifc.bus_timeout), 32'h1);
    chk("t5.stall_cycles", ifc.stall_cycles, 32'(exp_cnt));

    // reset during FLUSH_WAIT drops the redirect
    cyc("t6.enter", 4'b1000, 1'b1, 32'hC0, 6'b011111, 1'b0, 0);
    rst = 1'b1;
    cyc("t6.rst", 4'b1000, 1'b0, 0, 6'b000000, 1'b0, 0);
    rst = 1'b0;
    chk("t6.bus_timeout", 32'(ifc.bus_timeout), 32'h0);
    chk("t6.stall_cycles", ifc.stall_cycles, 32'h0);
    cyc("t6.c1", 4'b0000, 1'b0, 0, 6'b000000, 1'b0, 0);
    cyc("t6.c2", 4'b0000, 1'b0, 0, 6'b000000, 1'b0, 0);
    cyc("t6.id", 4'b0010, 1'b0, 0, 6'b000111, 1'b0, 0);
    chk("t6.cnt_after", ifc.stall_cycles, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
